rst_sequencer: RTL and testbench
================================

Name: rst_sequencer

Overview:
- Sits directly downstream of the PLL/clock-divider block.
- Consumes the 96 MHz PLL clock, its power-on `n_reset` and the raw PLL `lock`.
- Produces staged, glitch-free, synchronously-deasserted resets for three domains: memory, peripherals and CPU.
- Also handles PLL lock loss and CPU-requested soft reset, and reports sequencing status.

Parameters:
- STABLE_CYCLES, 256: consecutive synchronized-lock-high cycles required before any release.
- STAGE_GAP, 8: cycles between successive domain releases.
- SW_RST_CYCLES, 16: cycles `n_rst_cpu`/`n_rst_periph` are held low after a soft-reset request.
- CNT_W, 9: width of the shared timer; must hold max(STABLE_CYCLES, STAGE_GAP, SW_RST_CYCLES).

Ports:
- clk_96M  in  1  PLL output clock; all logic on its rising edge.
- n_reset  in  1  asynchronous, active-low reset (power-on reset from the clock block).
- lock  in  1  raw PLL lock; asynchronous to clk_96M.
- sw_rst_req  in  1  single-cycle soft-reset request, clk_96M-synchronous.
- n_rst_mem  out  1  active-low reset, memory domain.
- n_rst_periph  out  1  active-low reset, peripheral domain.
- n_rst_cpu  out  1  active-low reset, CPU domain.
- ready  out  1  high only in RUN.
- lock_lost_cnt  out  8  saturating count of lock-loss events since n_reset.

Behaviour:
- Reset is asynchronous and active-low. While `n_reset`=0:
  - all `n_rst_*`=0, `ready`=0, `lock_lost_cnt`=0;
  - state=HOLD, timer=0, sync flops=0.
- All outputs are registered; no combinational path from any input to any output.
- Lock is synchronized with a 2-FF chain, giving `lock_s`; all decisions use `lock_s` only.
- States:
  - HOLD: all resets low, timer=0. Go to STABLE when `lock_s`=1.
  - STABLE: timer increments each cycle while `lock_s`=1. On timer==STABLE_CYCLES-1, go to REL_MEM, timer=0, `n_rst_mem`<=1.
  - REL_MEM: on timer==STAGE_GAP-1, go to REL_PER, timer=0, `n_rst_periph`<=1.
  - REL_PER: on timer==STAGE_GAP-1, go to RUN, `n_rst_cpu`<=1, `ready`<=1.
  - RUN: steady state. On `sw_rst_req`=1, go to SW_HOLD, timer=0, `n_rst_cpu`<=0, `n_rst_periph`<=0, `ready`<=0. `n_rst_mem` stays 1.
  - SW_HOLD: on timer==SW_RST_CYCLES-1, go to REL_PER, timer=0, `n_rst_periph`<=1. The normal REL_PER path then releases `n_rst_cpu` STAGE_GAP cycles later.
- Lock loss: `lock_s`=0 in any state other than HOLD:
  - next edge: state=HOLD, all three resets 0, `ready`=0, timer=0;
  - `lock_lost_cnt` increments, saturating at 255.
  - In STABLE this aborts the count; the next `lock_s` rise restarts it from 0.
- Simultaneous events:
  - lock loss has priority over `sw_rst_req` and over any timer expiry;
  - `sw_rst_req` outside RUN is ignored, including during SW_HOLD (no extension).
- Timing from `n_reset` high with `lock` already high:
  - first edge samples lock; `lock_s`=1 after edge 2;
  - `n_rst_mem` rises at edge 2+STABLE_CYCLES;
  - `n_rst_periph` rises STAGE_GAP edges later;
  - `n_rst_cpu` and `ready` rise another STAGE_GAP edges later.
- Outputs never glitch low-high-low within a cycle; all deassertion is synchronous to clk_96M.

Decomposition:
- Shared package (rst_pkg):
  - state enum: HOLD, STABLE, REL_MEM, REL_PER, RUN, SW_HOLD;
  - default timing constants;
  - lock-loss counter width (8).
- One sub-module, `sync2`: 2-FF synchronizer with async active-low clear, reset value 0. Reused for `lock`, and later by other blocks crossing into the divided clocks.
- The FSM, timer and saturating counter stay in rst_sequencer.

Test Plan:
- Power-up, defaults, `lock`=1 before `n_reset` rises → `n_rst_mem` rises at edge 258, `n_rst_periph` at 266, `n_rst_cpu`/`ready` at 274; `lock_lost_cnt`=0.
- `lock` drops for 1 cycle at edge 100 (during STABLE) → all resets stay 0, `lock_lost_cnt`=1. Count restarts when `lock_s` returns; `n_rst_mem` rises 256 edges after `lock_s` re-rises.
- In RUN, pulse `sw_rst_req` → next edge `n_rst_cpu`=`n_rst_periph`=0 and `ready`=0, `n_rst_mem` stays 1. `n_rst_periph` back to 1 after 16 cycles, `n_rst_cpu`/`ready` 8 cycles after that.
- `sw_rst_req` and `lock` loss in the same cycle during RUN → HOLD with all three resets 0 (lock-loss priority); a second `sw_rst_req` during SW_HOLD does not extend the 16-cycle hold.
- Toggle `lock` 300 times → `lock_lost_cnt` saturates at 255, no wrap.
- Assert `n_reset`=0 mid-REL_MEM, between edges → all outputs 0 immediately, without waiting for a clock edge; on release the full sequence repeats with the timing of scenario 1.

Source files
------------

// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding and default timing.
package rst_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    STABLE  = 3'd1,
    REL_MEM = 3'd2,
    REL_PER = 3'd3,
    RUN     = 3'd4,
    SW_HOLD = 3'd5
  } state_t;

  localparam int unsigned DEF_STABLE_CYCLES = 256;
  localparam int unsigned DEF_STAGE_GAP     = 8;
  localparam int unsigned DEF_SW_RST_CYCLES = 16;
  localparam int unsigned DEF_CNT_W         = 9;
  localparam int unsigned LOST_CNT_W        = 8;

endpackage

// File: rtl/rst_sequencer_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear; output resets to 0.
module sync2 (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release for memory, peripheral and CPU domains after PLL lock,
// with lock-loss recovery, soft reset and a saturating lock-loss counter.
module rst_sequencer
  import rst_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP     = DEF_STAGE_GAP,
  parameter int unsigned SW_RST_CYCLES = DEF_SW_RST_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                  clk_96M,
  input  logic                  n_reset,
  input  logic                  lock,
  input  logic                  sw_rst_req,
  output logic                  n_rst_mem,
  output logic                  n_rst_periph,
  output logic                  n_rst_cpu,
  output logic                  ready,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

  localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0]      SW_LAST     = CNT_W'(SW_RST_CYCLES - 1);
  localparam logic [LOST_CNT_W-1:0] LOST_MAX    = '1;

  logic              lock_s;
  state_t            state;
  logic [CNT_W-1:0]  timer;

  sync2 u_lock_sync (
    .clk     (clk_96M),
    .n_reset (n_reset),
    .d       (lock),
    .q       (lock_s)
  );

  always_ff @(posedge clk_96M or negedge n_reset) begin
    if (!n_reset) begin
      state         <= HOLD;
      timer         <= '0;
      n_rst_mem     <= 1'b0;
      n_rst_periph  <= 1'b0;
      n_rst_cpu     <= 1'b0;
      ready         <= 1'b0;
      lock_lost_cnt <= '0;
    end else if (!lock_s) begin
      // Lock loss outranks soft-reset requests and timer expiry.
      state        <= HOLD;
      timer        <= '0;
      n_rst_mem    <= 1'b0;
      n_rst_periph <= 1'b0;
      n_rst_cpu    <= 1'b0;
      ready        <= 1'b0;
      if (state != HOLD && lock_lost_cnt != LOST_MAX) begin
        lock_lost_cnt <= lock_lost_cnt + 1'b1;
      end
    end else begin
      case (state)
        HOLD: begin
          // The cycle that observes lock_s high is the first stable cycle.
          state <= STABLE;
          timer <= CNT_W'(1);
        end
        STABLE: begin
          if (timer == STABLE_LAST) begin
            state     <= REL_MEM;
            timer     <= '0;
            n_rst_mem <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REL_MEM: begin
          if (timer == GAP_LAST) begin
            state        <= REL_PER;
            timer        <= '0;
            n_rst_periph <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REL_PER: begin
          if (timer == GAP_LAST) begin
            state     <= RUN;
            timer     <= '0;
            n_rst_cpu <= 1'b1;
            ready     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RUN: begin
          if (sw_rst_req) begin
            state        <= SW_HOLD;
            timer        <= '0;
            n_rst_periph <= 1'b0;
            n_rst_cpu    <= 1'b0;
            ready        <= 1'b0;
          end
        end
        SW_HOLD: begin
          if (timer == SW_LAST) begin
            state        <= REL_PER;
            timer        <= '0;
            n_rst_periph <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state        <= HOLD;
          timer        <= '0;
          n_rst_mem    <= 1'b0;
          n_rst_periph <= 1'b0;
          n_rst_cpu    <= 1'b0;
          ready        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: power-up timing, lock loss, soft reset,
// counter saturation and asynchronous reset.
module tb_rst_sequencer;

  logic       clk_96M = 1'b0;
  logic       n_reset;
  logic       lock;
  logic       sw_rst_req;
  logic       n_rst_mem;
  logic       n_rst_periph;
  logic       n_rst_cpu;
  logic       ready;
  logic [7:0] lock_lost_cnt;

  int total = 0;
  int bad   = 0;

  rst_sequencer dut (
    .clk_96M       (clk_96M),
    .n_reset       (n_reset),
    .lock          (lock),
    .sw_rst_req    (sw_rst_req),
    .n_rst_mem     (n_rst_mem),
    .n_rst_periph  (n_rst_periph),
    .n_rst_cpu     (n_rst_cpu),
    .ready         (ready),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 clk_96M = ~clk_96M;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_96M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[%0t] %s observed=%h expected=%h", $time, tag, obs, exp);
  endtask

  // Packs {mem, periph, cpu, ready} for a single comparison.
  task automatic chk_rst(input string tag, input logic [3:0] exp);
    chk(tag, {4'b0, n_rst_mem, n_rst_periph, n_rst_cpu, ready}, {4'b0, exp});
  endtask

  // Release n_reset between edges with lock already high and check the
  // power-up timeline counted from the first edge after release.
  task automatic powerup_seq(input string pfx);
    @(negedge clk_96M);
    n_reset = 1'b1;
    tick(257);
    chk_rst({pfx, "_e257"}, 4'b0000);
    tick(1);
    chk_rst({pfx, "_e258_mem"}, 4'b1000);
    tick(7);
    chk_rst({pfx, "_e265"}, 4'b1000);
    tick(1);
    chk_rst({pfx, "_e266_per"}, 4'b1100);
    tick(7);
    chk_rst({pfx, "_e273"}, 4'b1100);
    tick(1);
    chk_rst({pfx, "_e274_cpu"}, 4'b1111);
    chk({pfx, "_cnt"}, lock_lost_cnt, 8'd0);
  endtask

  initial begin
    n_reset    = 1'b0;
    lock       = 1'b1;
    sw_rst_req = 1'b0;

    // Reset state
    #12;
    chk_rst("rst_outs", 4'b0000);
    chk("rst_cnt", lock_lost_cnt, 8'd0);
    tick(3);
    chk_rst("rst_outs_clocked", 4'b0000);

    // Power-up sequence
    powerup_seq("pwr");

    // Soft reset in RUN
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk_rst("sw_e0", 4'b1000);
    tick(15);
    chk_rst("sw_e15", 4'b1000);
    tick(1);
    chk_rst("sw_e16_per", 4'b1100);
    tick(7);
    chk_rst("sw_e23", 4'b1100);
    tick(1);
    chk_rst("sw_e24_cpu", 4'b1111);

    // Lock loss and soft request in the same cycle
    lock = 1'b0;
    tick(2);
    chk_rst("simul_pre", 4'b1111);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk_rst("simul_hold", 4'b0000);
    chk("simul_cnt", lock_lost_cnt, 8'd1);
    tick(3);
    chk_rst("simul_stay", 4'b0000);

    // One-cycle lock glitch ~100 edges into STABLE
    lock = 1'b1;
    tick(98);
    lock = 1'b0;
    tick(1);
    lock = 1'b1;
    tick(1);
    chk("glitch_cnt_pre", lock_lost_cnt, 8'd1);
    tick(1);
    chk("glitch_cnt", lock_lost_cnt, 8'd2);
    chk_rst("glitch_outs", 4'b0000);
    tick(255);
    chk_rst("restart_e255", 4'b0000);
    tick(1);
    chk_rst("restart_e256_mem", 4'b1000);
    tick(8);
    chk_rst("restart_per", 4'b1100);
    tick(8);
    chk_rst("restart_cpu", 4'b1111);

    // Second request during SW_HOLD must not extend the hold
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk_rst("sw2_e0", 4'b1000);
    tick(4);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(10);
    chk_rst("sw2_e15", 4'b1000);
    tick(1);
    chk_rst("sw2_e16_per", 4'b1100);
    tick(8);
    chk_rst("sw2_e24_cpu", 4'b1111);

    // Lock toggling: counter saturates without wrapping
    for (int i = 0; i < 300; i++) begin
      lock = 1'b0;
      tick(4);
      lock = 1'b1;
      tick(4);
      if (i == 99) chk("sat_cnt_100", lock_lost_cnt, 8'd102);
    end
    chk("sat_cnt_300", lock_lost_cnt, 8'd255);

    // Reach REL_MEM, then assert n_reset between edges
    tick(257);
    chk_rst("relmem_outs", 4'b1000);
    chk("relmem_cnt", lock_lost_cnt, 8'd255);
    #3;
    n_reset = 1'b0;
    #1;
    chk_rst("async_outs", 4'b0000);
    chk("async_cnt", lock_lost_cnt, 8'd0);
    tick(2);
    chk_rst("async_held", 4'b0000);

    powerup_seq("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
